// File: rtl/sub_arbiter.sv
// sub_arbiter: shares one registered subtract operator among NREQ requesters and routes results back by tag.
// Define SUB_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins); the default build is round-robin.
module sub_arbiter #(
  parameter int N    = 16,
  parameter int NREQ = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic [NREQ-1:0]   i_req,
  input  logic [NREQ*N-1:0] i_req_a,
  input  logic [NREQ*N-1:0] i_req_b,
  output logic [NREQ-1:0]   o_ack,
  output logic [NREQ-1:0]   o_rsp_v,
  output logic [N-1:0]      o_rsp_d,
  output logic              o_err,
  output logic              o_op_en,
  output logic              o_op_r_in1,
  output logic              o_op_r_in2,
  output logic [N-1:0]      o_op_d_in1,
  output logic [N-1:0]      o_op_d_in2,
  input  logic              i_op_r_out,
  input  logic [N-1:0]      i_op_d_out
);

  localparam int              IDW     = $clog2(NREQ);
  localparam logic [IDW:0]    NREQ_W  = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0]  LAST_ID = IDW'(NREQ-1);
  localparam logic [NREQ-1:0] ONE_HOT = NREQ'(1);

  logic            r_gnt_v;
  logic [IDW-1:0]  r_gnt_id;
  logic [N-1:0]    r_gnt_a;
  logic [N-1:0]    r_gnt_b;
  logic            r_v_o;
  logic [IDW-1:0]  r_tag_o;
  logic [IDW-1:0]  r_ptr;
  logic [NREQ-1:0] r_ack;
  logic            r_en_q;
  logic            r_err;

  logic [NREQ-1:0] w_elig;
  logic [IDW:0]    w_sum;
  logic [IDW:0]    w_idx;
  logic            w_found;
  logic [IDW-1:0]  w_win;
  logic [IDW-1:0]  w_ptr_nxt;
  logic [NREQ-1:0] w_ack_nxt;
  logic [N-1:0]    w_sel_a;
  logic [N-1:0]    w_sel_b;

  // A requester just acknowledged gets one cycle to drop or replace its request.
  assign w_elig = i_req & ~r_ack;

  // Winner search: first eligible index starting at the pointer, wrapping modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      w_sum = {1'b0, r_ptr} + (IDW+1)'(k);
      w_idx = (w_sum >= NREQ_W) ? (w_sum - NREQ_W) : w_sum;
      if (!w_found && w_elig[w_idx[IDW-1:0]]) begin
        w_found = 1'b1;
        w_win   = w_idx[IDW-1:0];
      end else begin
        w_found = w_found;
      end
    end
  end

`ifdef SUB_ARB_FIXED_PRIO_EN
  assign w_ptr_nxt = '0;
`else
  assign w_ptr_nxt = (w_win == LAST_ID) ? '0 : (w_win + IDW'(1));
`endif

  assign w_ack_nxt = (i_en && w_found) ? (ONE_HOT << w_win) : '0;
  assign w_sel_a   = i_req_a[w_win*N +: N];
  assign w_sel_b   = i_req_b[w_win*N +: N];

  // Grant and operator-tag stages; everything here freezes while EN is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_gnt_v  <= 1'b0;
      r_gnt_id <= '0;
      r_gnt_a  <= '0;
      r_gnt_b  <= '0;
      r_v_o    <= 1'b0;
      r_tag_o  <= '0;
      r_ptr    <= '0;
    end else if (i_en) begin
      r_gnt_v <= w_found;
      if (w_found) begin
        r_gnt_id <= w_win;
        r_gnt_a  <= w_sel_a;
        r_gnt_b  <= w_sel_b;
        r_ptr    <= w_ptr_nxt;
      end
      r_v_o   <= r_gnt_v;
      r_tag_o <= r_gnt_id;
    end
  end

  // ACK is a single-cycle pulse even across stalls; en_q and the sticky error run every edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ack  <= '0;
      r_en_q <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_ack  <= w_ack_nxt;
      r_en_q <= i_en;
      r_err  <= r_err | (r_v_o & r_en_q & ~i_op_r_out);
    end
  end

  // Gating with en_q keeps a held v_o from strobing again after a stall.
  always_comb begin
    o_rsp_v = '0;
    for (int i = 0; i < NREQ; i++) begin
      o_rsp_v[i] = r_v_o & r_en_q & (r_tag_o == IDW'(i));
    end
  end

  assign o_ack      = r_ack;
  assign o_rsp_d    = i_op_d_out;
  assign o_err      = r_err;
  assign o_op_en    = i_en;
  assign o_op_r_in1 = r_gnt_v;
  assign o_op_r_in2 = r_gnt_v;
  assign o_op_d_in1 = r_gnt_a;
  assign o_op_d_in2 = r_gnt_b;

endmodule
